// File: rtl/pakout_arb.sv
// pakout_arb: round-robin arbiter sharing one toggle-handshake packet link
// among NIN sources; drops packets with out-of-range destinations.
// Ports:
//   i_clk, reset (sync, active-high)  ready     : 0 in reset cycle, then 1
//   rcv_req/ack/pak : NIN input links (two-phase toggle handshake)
//   snd_req/ack/pak : single output link (snd_pak registered)
//   o_grant   : one-hot owner of the output, 0 when idle
//   o_err     : sticky drop flag      o_fst_err : first dropped packet
//   o_fwd_cnt : wrapping count of forwarded packets

`ifndef NS_ADDRESS_SIZE
`define NS_ADDRESS_SIZE 6
`endif
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 4
`endif

module pakout_arb #(
  parameter int NIN      = 4,
  parameter int ASZ      = `NS_ADDRESS_SIZE,
  parameter int DSZ      = `NS_DATA_SIZE,
  parameter int PSZ      = ASZ + DSZ,
  parameter int MIN_ADDR = 0,
  parameter int MAX_ADDR = 55,
  parameter int CSZ      = 16
) (
  input  logic               i_clk,
  input  logic               reset,
  output logic               ready,
  input  logic [NIN-1:0]     rcv_req,
  output logic [NIN-1:0]     rcv_ack,
  input  logic [NIN*PSZ-1:0] rcv_pak,
  output logic               snd_req,
  input  logic               snd_ack,
  output logic [PSZ-1:0]     snd_pak,
  output logic [NIN-1:0]     o_grant,
  output logic               o_err,
  output logic [PSZ-1:0]     o_fst_err,
  output logic [CSZ-1:0]     o_fwd_cnt
);

  localparam int PW = (NIN > 1) ? $clog2(NIN) : 1;

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  state_t         r_state, w_state;
  logic [PW-1:0]  r_rr, w_rr;
  logic [PW-1:0]  r_sel, w_sel;
  logic           r_ready;
  logic           r_snd_req, w_snd_req;
  logic [NIN-1:0] r_rcv_ack, w_rcv_ack;
  logic [PSZ-1:0] r_snd_pak, w_snd_pak;
  logic [NIN-1:0] r_grant, w_grant;
  logic           r_err, w_err;
  logic [PSZ-1:0] r_fst, w_fst;
  logic [CSZ-1:0] r_cnt, w_cnt;

  logic [NIN-1:0] w_pend;
  logic [PW-1:0]  w_pick;
  logic           w_found;
  logic [PSZ-1:0] w_pak;
  logic [ASZ-1:0] w_dst;
  logic           w_legal;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] s
  );
    if (int'(s) == NIN - 1) return '0;
    return s + PW'(1);
  endfunction

  // Scan from rr_ptr upward; iterating downward lets
  // the lowest offset win the final assignment.
  always_comb begin
    int j;
    j       = 0;
    w_pend  = rcv_req ^ r_rcv_ack;
    w_found = 1'b0;
    w_pick  = '0;
    for (int k = NIN - 1; k >= 0; k--) begin
      j = int'(r_rr) + k;
      if (j >= NIN) j = j - NIN;
      if (w_pend[PW'(j)]) begin
        w_found = 1'b1;
        w_pick  = PW'(j);
      end
    end
  end

  always_comb begin
    w_pak   = rcv_pak[int'(w_pick)*PSZ +: PSZ];
    w_dst   = w_pak[PSZ-1 -: ASZ];
    w_legal = (int'(w_dst) >= MIN_ADDR)
           && (int'(w_dst) <= MAX_ADDR);
  end

  always_comb begin
    w_state   = r_state;
    w_rr      = r_rr;
    w_sel     = r_sel;
    w_snd_req = r_snd_req;
    w_rcv_ack = r_rcv_ack;
    w_snd_pak = r_snd_pak;
    w_grant   = r_grant;
    w_err     = r_err;
    w_fst     = r_fst;
    w_cnt     = r_cnt;
    unique case (r_state)
      S_IDLE: begin
        if (w_found && w_legal) begin
          w_snd_pak = w_pak;
          w_snd_req = ~r_snd_req;
          w_grant   = NIN'(1) << w_pick;
          w_sel     = w_pick;
          w_state   = S_WAIT;
        end else if (w_found) begin
          // Drop: ack the source directly, link untouched.
          w_rcv_ack[w_pick] = ~r_rcv_ack[w_pick];
          w_err = 1'b1;
          if (!r_err) w_fst = w_pak;
          w_rr = nxt(w_pick);
        end
      end
      S_WAIT: begin
        if (snd_ack == r_snd_req) begin
          w_rcv_ack[r_sel] = ~r_rcv_ack[r_sel];
          w_cnt   = r_cnt + CSZ'(1);
          w_rr    = nxt(r_sel);
          w_grant = '0;
          w_state = S_IDLE;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_rr      <= '0;
      r_sel     <= '0;
      r_ready   <= 1'b0;
      r_snd_req <= 1'b0;
      r_rcv_ack <= '0;
      r_snd_pak <= '0;
      r_grant   <= '0;
      r_err     <= 1'b0;
      r_fst     <= '0;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_state;
      r_rr      <= w_rr;
      r_sel     <= w_sel;
      r_ready   <= 1'b1;
      r_snd_req <= w_snd_req;
      r_rcv_ack <= w_rcv_ack;
      r_snd_pak <= w_snd_pak;
      r_grant   <= w_grant;
      r_err     <= w_err;
      r_fst     <= w_fst;
      r_cnt     <= w_cnt;
    end
  end

  assign ready     = r_ready;
  assign snd_req   = r_snd_req;
  assign rcv_ack   = r_rcv_ack;
  assign snd_pak   = r_snd_pak;
  assign o_grant   = r_grant;
  assign o_err     = r_err;
  assign o_fst_err = r_fst;
  assign o_fwd_cnt = r_cnt;

endmodule

// File: tb/tb_pakout_arb.sv
// tb_pakout_arb: directed + randomized bench for pakout_arb
// against a transaction-level model of arbitration, drops and counting.

module tb_pakout_arb;

  localparam int NIN = 4;
  localparam int ASZ = 6;
  localparam int DSZ = 4;
  localparam int PSZ = 10;
  localparam int CSZ = 4;
  localparam int MAXA = 55;

  logic               clk = 1'b0;
  logic               reset;
  logic               ready;
  logic [NIN-1:0]     rcv_req;
  logic [NIN-1:0]     rcv_ack;
  logic [NIN*PSZ-1:0] rcv_pak;
  logic               snd_req;
  logic               snd_ack;
  logic [PSZ-1:0]     snd_pak;
  logic [NIN-1:0]     grant;
  logic               err;
  logic [PSZ-1:0]     fst;
  logic [CSZ-1:0]     cnt;

  logic [PSZ-1:0] pk [NIN];

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NIN; i++)
      rcv_pak[i*PSZ +: PSZ] = pk[i];
  end

  pakout_arb #(
    .NIN(NIN), .ASZ(ASZ), .DSZ(DSZ), .PSZ(PSZ),
    .MIN_ADDR(0), .MAX_ADDR(MAXA), .CSZ(CSZ)
  ) dut (
    .i_clk(clk), .reset(reset), .ready(ready),
    .rcv_req(rcv_req), .rcv_ack(rcv_ack),
    .rcv_pak(rcv_pak), .snd_req(snd_req),
    .snd_ack(snd_ack), .snd_pak(snd_pak),
    .o_grant(grant), .o_err(err),
    .o_fst_err(fst), .o_fwd_cnt(cnt)
  );

  // Reference model state
  logic [NIN-1:0] m_ack;
  int             m_rr;
  int             m_cnt;
  logic           m_err;
  logic [PSZ-1:0] m_fst;
  logic           m_sreq;

  int cmp = 0;
  int mism = 0;

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    cmp++;
    assert (obs === exp) else begin
      mism++;
      $error("FAIL %s: observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mreset();
    m_ack  = '0;
    m_rr   = 0;
    m_cnt  = 0;
    m_err  = 1'b0;
    m_fst  = '0;
    m_sreq = 1'b0;
  endtask

  function automatic int pick();
    logic [NIN-1:0] p;
    p = rcv_req ^ m_ack;
    for (int k = 0; k < NIN; k++)
      if (p[(m_rr + k) % NIN]) return (m_rr + k) % NIN;
    return -1;
  endfunction

  function automatic logic [PSZ-1:0] legal_pak();
    logic [ASZ-1:0] d;
    logic [DSZ-1:0] v;
    d = ASZ'($urandom_range(MAXA, 0));
    v = DSZ'($urandom);
    return {d, v};
  endfunction

  task automatic do_reset(int n);
    reset   = 1'b1;
    rcv_req = '0;
    snd_ack = 1'b0;
    repeat (n) tick();
    chk("rst ready", ready, 0);
    chk("rst snd_req", snd_req, 0);
    chk("rst rcv_ack", rcv_ack, 0);
    chk("rst snd_pak", snd_pak, 0);
    chk("rst grant", grant, 0);
    chk("rst err", err, 0);
    chk("rst fst", fst, 0);
    chk("rst cnt", cnt, 0);
    reset = 1'b0;
    mreset();
  endtask

  task automatic pend(int i, logic [PSZ-1:0] p);
    pk[i]      = p;
    rcv_req[i] = ~rcv_req[i];
  endtask

  // One arbitration decision: either a full forward
  // with d wait cycles before the sink acks, or a drop.
  task automatic serve(int d, bit mutate);
    int             s;
    int             k;
    logic [PSZ-1:0] p;
    s = pick();
    if (s < 0) return;
    p = pk[s];
    tick();
    if (p[PSZ-1 -: ASZ] <= ASZ'(MAXA)) begin
      m_sreq = ~m_sreq;
      chk("grant snd_req", snd_req, m_sreq);
      chk("grant snd_pak", snd_pak, p);
      chk("grant onehot", grant, 32'(1) << s);
      chk("grant rcv_ack", rcv_ack, m_ack);
      for (int c = 0; c < d; c++) begin
        if (mutate) pk[s] = PSZ'($urandom);
        k = int'($urandom_range(NIN - 1, 0));
        if (mutate && k != s && rcv_req[k] == m_ack[k])
          pend(k, PSZ'($urandom));
        tick();
        chk("wait snd_pak", snd_pak, p);
        chk("wait grant", grant, 32'(1) << s);
        chk("wait snd_req", snd_req, m_sreq);
        chk("wait rcv_ack", rcv_ack, m_ack);
      end
      snd_ack = m_sreq;
      tick();
      m_ack[s] = ~m_ack[s];
      m_cnt    = (m_cnt + 1) % (1 << CSZ);
      m_rr     = (s + 1) % NIN;
      chk("done rcv_ack", rcv_ack, m_ack);
      chk("done grant", grant, 0);
      chk("done cnt", cnt, m_cnt);
    end else begin
      m_ack[s] = ~m_ack[s];
      if (!m_err) m_fst = p;
      m_err = 1'b1;
      m_rr  = (s + 1) % NIN;
      chk("drop rcv_ack", rcv_ack, m_ack);
      chk("drop snd_req", snd_req, m_sreq);
      chk("drop grant", grant, 0);
      chk("drop err", err, m_err);
      chk("drop fst", fst, m_fst);
      chk("drop cnt", cnt, m_cnt);
    end
  endtask

  task automatic drain(int dmax);
    int guard;
    guard = 0;
    while (pick() >= 0 && guard < 64) begin
      serve(int'($urandom_range(dmax, 0)), 1'b1);
      guard++;
    end
    chk("drain done", guard < 64, 1);
  endtask

  initial begin
    int s;
    logic [PSZ-1:0] p;
    reset   = 1'b1;
    rcv_req = '0;
    snd_ack = 1'b0;
    for (int i = 0; i < NIN; i++) pk[i] = '0;

    // Reset and ready
    do_reset(2);
    tick();
    chk("ready after rst", ready, 1);
    chk("idle grant", grant, 0);

    // Single transfer with late ack
    pend(1, {6'd23, 4'd5});
    serve(3, 1'b0);
    chk("single cnt", cnt, 1);

    // Round robin from a fresh pointer
    do_reset(1);
    for (int i = 0; i < NIN; i++) pend(i, legal_pak());
    repeat (4) serve(0, 1'b0);
    pend(2, legal_pak());
    pend(0, legal_pak());
    serve(0, 1'b0);
    serve(0, 1'b0);

    // Drops
    p = {6'd60, 4'($urandom)};
    pend(2, p);
    serve(0, 1'b0);
    pend(2, {6'd57, 4'($urandom)});
    serve(0, 1'b0);
    chk("drop first kept", fst, p);

    // Random traffic
    repeat (40) begin
      for (int i = 0; i < NIN; i++)
        if (rcv_req[i] == m_ack[i] && $urandom_range(1, 0) == 1)
          pend(i, PSZ'($urandom));
      drain(3);
    end

    // Reset during WAIT
    pend(3, legal_pak());
    s = pick();
    tick();
    m_sreq = ~m_sreq;
    chk("mid grant", grant, 32'(1) << s);
    chk("mid snd_req", snd_req, m_sreq);
    reset   = 1'b1;
    rcv_req = '0;
    snd_ack = 1'b0;
    pk[0]   = legal_pak();
    rcv_req[0] = 1'b1;
    tick();
    chk("mid rst snd_req", snd_req, 0);
    chk("mid rst grant", grant, 0);
    chk("mid rst rcv_ack", rcv_ack, 0);
    tick();
    chk("mid rst held grant", grant, 0);
    chk("mid rst held ack", rcv_ack, 0);
    reset = 1'b0;
    mreset();
    serve(1, 1'b0);

    // Counter wrap
    do_reset(1);
    for (int n = 1; n <= 17; n++) begin
      s = int'($urandom_range(NIN - 1, 0));
      pend(s, legal_pak());
      serve(0, 1'b0);
      if (n == 15) chk("wrap 15", cnt, 15);
      if (n == 16) chk("wrap 0", cnt, 0);
      if (n == 17) chk("wrap 1", cnt, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             cmp, mism);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
